// File: rtl/omr_grading_controller.sv
// Sequential OMR grading engine: one question graded per clock between two valid/ready handshakes.
// Define OMR_NEG_MARKING_EN to report score as correct minus wrong, saturated at zero.
module omr_grading_controller #(
  parameter int unsigned NUM_Q = 10,
  parameter int unsigned OPT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_wr,
  input  logic [NUM_Q*OPT_W-1:0] correct_answers,
  input  logic                   sheet_valid,
  output logic                   sheet_ready,
  input  logic [NUM_Q*OPT_W-1:0] student_answers,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [3:0]             score,
  output logic [3:0]             score_neg,
  output logic [3:0]             blank_cnt,
  output logic                   key_err,
  output logic [7:0]             sheet_cnt
);

  localparam int unsigned W = NUM_Q * OPT_W;
  localparam logic [3:0] LastQ = 4'(NUM_Q - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e         state;
  logic [W-1:0]   key_reg;
  logic [W-1:0]   stud_sh;
  logic [W-1:0]   key_sh;
  logic [3:0]     q_idx;
  logic [3:0]     n_correct;

  logic [OPT_W-1:0] s_nib;
  logic [OPT_W-1:0] k_nib;
  logic             is_blank;
  logic             is_correct;
  logic [3:0]       correct_nx;
  logic [3:0]       wrong_nx;
  logic [3:0]       blank_nx;
  logic [3:0]       score_nx;

  // Both sheets shift down one question per cycle, so the current question is always the low nibble.
  always_comb begin
    s_nib      = stud_sh[OPT_W-1:0];
    k_nib      = key_sh[OPT_W-1:0];
    is_blank   = (s_nib == '0);
    is_correct = !is_blank && ((s_nib & (s_nib - OPT_W'(1))) == '0) && (s_nib == k_nib);
    correct_nx = n_correct + 4'(is_correct);
    wrong_nx   = score_neg + 4'(!is_blank && !is_correct);
    blank_nx   = blank_cnt + 4'(is_blank);
`ifdef OMR_NEG_MARKING_EN
    score_nx   = (correct_nx > wrong_nx) ? (correct_nx - wrong_nx) : 4'd0;
`else
    score_nx   = correct_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      key_reg     <= '0;
      stud_sh     <= '0;
      key_sh      <= '0;
      q_idx       <= '0;
      n_correct   <= '0;
      sheet_ready <= 1'b1;
      res_valid   <= 1'b0;
      score       <= '0;
      score_neg   <= '0;
      blank_cnt   <= '0;
      key_err     <= 1'b0;
      sheet_cnt   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (key_wr) key_reg <= correct_answers;
          if (sheet_valid) begin
            stud_sh     <= student_answers;
            // A key written in the acceptance cycle grades this sheet.
            key_sh      <= key_wr ? correct_answers : key_reg;
            q_idx       <= '0;
            n_correct   <= '0;
            score       <= '0;
            score_neg   <= '0;
            blank_cnt   <= '0;
            sheet_ready <= 1'b0;
            state       <= StScan;
          end
        end
        StScan: begin
          if (key_wr) key_err <= 1'b1;
          stud_sh   <= stud_sh >> OPT_W;
          key_sh    <= key_sh >> OPT_W;
          n_correct <= correct_nx;
          score_neg <= wrong_nx;
          blank_cnt <= blank_nx;
          score     <= score_nx;
          q_idx     <= q_idx + 4'd1;
          if (q_idx == LastQ) begin
            res_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (key_wr) key_err <= 1'b1;
          if (res_ready) begin
            res_valid   <= 1'b0;
            sheet_ready <= 1'b1;
            sheet_cnt   <= sheet_cnt + 8'd1;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_omr_grading_controller.sv
// Directed plus randomized bench for omr_grading_controller with a per-question reference model.
module tb_omr_grading_controller;

  localparam int NQ = 10;
  localparam int OW = 4;
  localparam int W  = NQ * OW;
  localparam logic [W-1:0] KEY = 40'h1224121888;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_wr;
  logic [W-1:0] correct_answers;
  logic         sheet_valid;
  logic         sheet_ready;
  logic [W-1:0] student_answers;
  logic         res_valid;
  logic         res_ready;
  logic [3:0]   score;
  logic [3:0]   score_neg;
  logic [3:0]   blank_cnt;
  logic         key_err;
  logic [7:0]   sheet_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] key_m;
  logic [7:0]   cnt_m;
  logic         kerr_m;

  omr_grading_controller #(.NUM_Q(NQ), .OPT_W(OW)) dut (
    .clk             (clk),
    .reset           (reset),
    .key_wr          (key_wr),
    .correct_answers (correct_answers),
    .sheet_valid     (sheet_valid),
    .sheet_ready     (sheet_ready),
    .student_answers (student_answers),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .score           (score),
    .score_neg       (score_neg),
    .blank_cnt       (blank_cnt),
    .key_err         (key_err),
    .sheet_cnt       (sheet_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference grading straight from the marking rules.
  function automatic void grade(input logic [W-1:0] k, input logic [W-1:0] s,
                                output int c, output int w, output int b);
    logic [OW-1:0] sn;
    logic [OW-1:0] kn;
    c = 0; w = 0; b = 0;
    for (int i = 0; i < NQ; i++) begin
      sn = OW'(s >> (OW * i));
      kn = OW'(k >> (OW * i));
      if (sn == 0) b++;
      else if ($countones(sn) == 1 && sn == kn) c++;
      else w++;
    end
  endfunction

  function automatic int exp_score(input int c, input int w);
`ifdef OMR_NEG_MARKING_EN
    return (c > w) ? c - w : 0;
`else
    return c;
`endif
  endfunction

  function automatic logic [W-1:0] rand_key();
    logic [W-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < NQ; i++) begin
      r = $urandom_range(0, 9);
      v[i*OW +: OW] = (r < 8) ? OW'(1 << $urandom_range(0, OW - 1)) : OW'($urandom_range(0, 15));
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rand_stud(input logic [W-1:0] k);
    logic [W-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < NQ; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      v[i*OW +: OW] = '0;
      else if (r < 6) v[i*OW +: OW] = k[i*OW +: OW];
      else if (r < 8) v[i*OW +: OW] = OW'(1 << $urandom_range(0, OW - 1));
      else            v[i*OW +: OW] = OW'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic run_sheet(input bit do_key, input logic [W-1:0] k, input logic [W-1:0] s,
                           input int hold, input bit kw_scan, input string tag);
    int c, w, b, cyc, sc;
    check({tag, ".ready"}, {31'd0, sheet_ready}, 32'd1);
    key_wr = do_key; correct_answers = k; student_answers = s; sheet_valid = 1'b1;
    step();
    key_wr = 1'b0; sheet_valid = 1'b0;
    if (do_key) key_m = k;
    grade(key_m, s, c, w, b);
    sc = exp_score(c, w);
    check({tag, ".busy"}, {31'd0, sheet_ready}, 32'd0);
    cyc = 0;
    while (!res_valid && cyc < 4 * NQ) begin
      student_answers = W'({$urandom, $urandom});
      correct_answers = W'({$urandom, $urandom});
      key_wr = kw_scan && (cyc == 2);
      step();
      cyc++;
    end
    key_wr = 1'b0;
    if (kw_scan) kerr_m = 1'b1;
    check({tag, ".latency"}, cyc, NQ);
    check({tag, ".score"}, {28'd0, score}, sc);
    check({tag, ".neg"}, {28'd0, score_neg}, w);
    check({tag, ".blank"}, {28'd0, blank_cnt}, b);
    check({tag, ".key_err"}, {31'd0, key_err}, {31'd0, kerr_m});
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, ".hold"}, {18'd0, res_valid, sheet_ready, score, score_neg, blank_cnt},
            {18'd0, 1'b1, 1'b0, 4'(sc), 4'(w), 4'(b)});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    cnt_m++;
    check({tag, ".consume"}, {22'd0, res_valid, sheet_ready, sheet_cnt},
          {22'd0, 1'b0, 1'b1, cnt_m});
  endtask

  initial begin
    reset = 1'b1; key_wr = 1'b0; sheet_valid = 1'b0; res_ready = 1'b0;
    correct_answers = '0; student_answers = '0;
    key_m = '0; cnt_m = '0; kerr_m = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset.ctl", {29'd0, sheet_ready, res_valid, key_err}, 32'b100);
    check("reset.res", {20'd0, score, score_neg, blank_cnt}, 32'd0);
    check("reset.cnt", {24'd0, sheet_cnt}, 32'd0);

    // Zero key: every mark is wrong.
    run_sheet(1'b0, KEY, KEY, 0, 1'b0, "nokey");

    key_wr = 1'b1; correct_answers = KEY;
    step();
    key_wr = 1'b0; key_m = KEY;

    run_sheet(1'b0, KEY, KEY, 0, 1'b0, "perfect");
    run_sheet(1'b0, KEY, 40'h8224242888, 0, 1'b0, "mixed");
    run_sheet(1'b1, KEY, 40'h8424424212, 0, 1'b0, "sat");
    run_sheet(1'b0, KEY, 40'h0000000003, 0, 1'b0, "blank");
    run_sheet(1'b0, KEY, 40'h8224242888, 5, 1'b1, "bp_kerr");
    run_sheet(1'b0, KEY, KEY, 0, 1'b0, "oldkey");
    run_sheet(1'b1, 40'h8888888888, 40'h8888888888, 1, 1'b0, "newkey");
    run_sheet(1'b1, KEY, 40'h1224121888, 0, 1'b0, "rekey");

    // Abort a sheet in its fourth SCAN cycle.
    correct_answers = KEY; student_answers = KEY; sheet_valid = 1'b1;
    step();
    sheet_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    key_m = '0; cnt_m = '0; kerr_m = 1'b0;
    check("abort.ctl", {21'd0, sheet_ready, res_valid, key_err, sheet_cnt}, 32'h400);
    check("abort.res", {20'd0, score, score_neg, blank_cnt}, 32'd0);
    step();
    check("abort.idle", {30'd0, sheet_ready, res_valid}, 32'b10);
    run_sheet(1'b1, KEY, KEY, 0, 1'b0, "post_rst");

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] rk;
      rk = rand_key();
      run_sheet($urandom_range(0, 1) == 1, rk, rand_stud(($urandom_range(0, 1) == 1) ? rk : key_m),
                $urandom_range(0, 3), $urandom_range(0, 5) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
